key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 13 +
 rtl/key_channel.sv | 149 ++++++++++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_pkg;

  localparam int N_KEYS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce FSM, and long-press timer.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_ONE  = DW'(1);
  localparam logic [LW-1:0] LG_MAX  = LW'(LONG_CYCLES);
  localparam logic          RAW_REL = (ACTIVE_LOW != 0);

  logic          r_sync1, r_sync2;
  logic          w_pressed;
  key_state_e    r_state, w_state_nx;
  logic [DW-1:0] r_db, w_db_nx, w_db_inc;
  logic [LW-1:0] r_lg, w_lg_nx, w_lg_inc;
  logic          r_level, r_press, r_release, r_long;
  logic          w_level_nx, w_press_nx, w_release_nx, w_long_nx;

  // Synchronizer idles at the released raw level so reset looks like "no key".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RAW_REL;
      r_sync2 <= RAW_REL;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ RAW_REL;
  assign w_db_inc  = (r_db == DB_MAX) ? r_db : r_db + DB_ONE;
  assign w_lg_inc  = r_lg + LW'(1);

  always_comb begin
    w_state_nx   = r_state;
    w_db_nx      = r_db;
    w_press_nx   = 1'b0;
    w_release_nx = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          if (DB_ONE == DB_MAX) begin
            w_state_nx = HELD;
            w_press_nx = 1'b1;
            w_db_nx    = '0;
          end else begin
            w_state_nx = PRESS_WAIT;
            w_db_nx    = DB_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nx = IDLE;
          w_db_nx    = '0;
        end else if (w_db_inc == DB_MAX) begin
          w_state_nx = HELD;
          w_press_nx = 1'b1;
          w_db_nx    = '0;
        end else begin
          w_db_nx = w_db_inc;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          if (DB_ONE == DB_MAX) begin
            w_state_nx   = IDLE;
            w_release_nx = 1'b1;
            w_db_nx      = '0;
          end else begin
            w_state_nx = RELEASE_WAIT;
            w_db_nx    = DB_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nx = HELD;
          w_db_nx    = '0;
        end else if (w_db_inc == DB_MAX) begin
          w_state_nx   = IDLE;
          w_release_nx = 1'b1;
          w_db_nx      = '0;
        end else begin
          w_db_nx = w_db_inc;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_db_nx    = '0;
      end
    endcase
  end

  // Long timer keeps running through a release glitch; it only restarts from IDLE/PRESS_WAIT.
  always_comb begin
    w_lg_nx   = '0;
    w_long_nx = 1'b0;
    if (r_state == HELD || r_state == RELEASE_WAIT) begin
      w_lg_nx = r_lg;
      if (r_lg != LG_MAX) begin
        w_lg_nx   = w_lg_inc;
        w_long_nx = (w_lg_inc == LG_MAX);
      end
    end
  end

  assign w_level_nx = (w_state_nx == HELD) || (w_state_nx == RELEASE_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_db      <= '0;
      r_lg      <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_db      <= w_db_nx;
      r_lg      <= w_lg_nx;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_long    <= w_long_nx;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/key_conditioner.sv
// Debounced press/release/long-press detection for N_KEYS independent buttons.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key    (i_key[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_long   (o_long[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: window-rule reference model feeds an expectation queue, a monitor checks outputs.
module tb_key_conditioner;
  localparam int NK = 3;
  localparam int D  = 8;
  localparam int L  = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] level, press, rel_o, lng;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
    .o_level(level), .o_press(press), .o_release(rel_o), .o_long(lng)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rls;
    logic [NK-1:0] lng;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: a level flips once the last D synchronized samples all disagree with it.
  bit d1[NK], d2[NK];
  bit win[NK][D];
  bit mlvl[NK];
  int hs[NK];

  always @(posedge clk) begin : model
    exp_t e;
    bit   s, all_opp;
    cyc = cyc + 1;
    e = '0;
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        d1[k] = 0; d2[k] = 0; mlvl[k] = 0; hs[k] = 0;
        for (int j = 0; j < D; j++) win[k][j] = 0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        s     = d2[k];
        d2[k] = d1[k];
        d1[k] = (key[k] == 1'b0);
        for (int j = D - 1; j > 0; j--) win[k][j] = win[k][j-1];
        win[k][0] = s;
        if (mlvl[k] && (cyc - hs[k] == L)) e.lng[k] = 1'b1;
        all_opp = 1;
        for (int j = 0; j < D; j++) if (win[k][j] == mlvl[k]) all_opp = 0;
        if (all_opp) begin
          mlvl[k] = !mlvl[k];
          if (mlvl[k]) begin e.prs[k] = 1'b1; hs[k] = cyc; end
          else e.rls[k] = 1'b1;
        end
        e.lvl[k] = mlvl[k];
      end
    end
    expq.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  int pcnt[NK], rcnt[NK], lcnt[NK], last_p[NK], last_r[NK], last_l[NK];
  bit lvl_hi[NK];

  task automatic clr_log();
    for (int k = 0; k < NK; k++) begin
      pcnt[k] = 0; rcnt[k] = 0; lcnt[k] = 0;
      last_p[k] = -1; last_r[k] = -1; last_l[k] = -1; lvl_hi[k] = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      if (!rst_n) x = '0;
      chk("level",   int'(level), int'(x.lvl));
      chk("press",   int'(press), int'(x.prs));
      chk("release", int'(rel_o), int'(x.rls));
      chk("long",    int'(lng),   int'(x.lng));
      for (int k = 0; k < NK; k++) begin
        if (press[k]) begin pcnt[k]++; last_p[k] = cyc; end
        if (rel_o[k]) begin rcnt[k]++; last_r[k] = cyc; end
        if (lng[k])   begin lcnt[k]++; last_l[k] = cyc; end
        if (level[k]) lvl_hi[k] = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0, e1;
    clr_log();
    // Key 0 held pressed through reset.
    rst_n = 1'b0;
    key   = 3'b110;
    tick(5);
    chk("reset_outputs", int'({level, press, rel_o, lng}), 0);
    clr_log();
    rst_n = 1'b1;
    e0 = cyc;
    tick(20);
    chk("rst_held_press_cnt", pcnt[0], 1);
    chk("rst_held_press_time", last_p[0], e0 + 10);
    key[0] = 1'b1;
    tick(20);

    // Reset in the middle of PRESS_WAIT aborts the press.
    clr_log();
    key[1] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(3);
    key[1] = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    chk("rst_abort_press", pcnt[1], 0);
    chk("rst_abort_level", int'(lvl_hi[1]), 0);

    // Clean press.
    clr_log();
    key[0] = 1'b0;
    e0 = cyc;
    tick(30);
    chk("clean_press_cnt", pcnt[0], 1);
    chk("clean_press_time", last_p[0], e0 + 10);
    chk("clean_level", int'(level[0]), 1);
    key[0] = 1'b1;
    tick(30);

    // Bounce train: runs of 3 never qualify.
    clr_log();
    for (int i = 0; i < 10; i++) begin
      key[1] = ~key[1];
      tick(3);
    end
    key[1] = 1'b1;
    tick(20);
    chk("bounce_pulses", pcnt[1] + rcnt[1] + lcnt[1], 0);
    chk("bounce_level", int'(lvl_hi[1]), 0);

    // Long hold.
    clr_log();
    key[2] = 1'b0;
    e0 = cyc;
    tick(100);
    key[2] = 1'b1;
    e1 = cyc;
    tick(20);
    chk("long_press_time", last_p[2], e0 + 10);
    chk("long_pulse_time", last_l[2], e0 + 50);
    chk("long_pulse_cnt", lcnt[2], 1);
    chk("long_release_time", last_r[2], e1 + 10);

    // 5-cycle release glitch while held.
    clr_log();
    key[0] = 1'b0;
    e0 = cyc;
    tick(20);
    key[0] = 1'b1;
    tick(5);
    key[0] = 1'b0;
    tick(45);
    key[0] = 1'b1;
    e1 = cyc;
    tick(20);
    chk("glitch_release_cnt", rcnt[0], 1);
    chk("glitch_release_time", last_r[0], e1 + 10);
    chk("glitch_long_time", last_l[0], e0 + 50);
    chk("glitch_long_cnt", lcnt[0], 1);

    // Simultaneous press.
    clr_log();
    key = '0;
    e0 = cyc;
    tick(20);
    for (int k = 0; k < NK; k++) chk($sformatf("simul_press_time%0d", k), last_p[k], e0 + 10);
    key = '1;
    tick(20);

    // Randomized segments with occasional reset.
    for (int i = 0; i < 200; i++) begin
      key = NK'($urandom_range(0, (1 << NK) - 1));
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      tick($urandom_range(1, 20));
    end
    key = '1;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
